// File: rtl/button_ctrl_pkg.sv
// rtl/button_ctrl_pkg.sv - shared repeat-state enum, default parameters and width helper
package button_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    localparam int DEF_N_BTN       = 4;
    localparam int DEF_CLK_DIV     = 50000;
    localparam int DEF_STABLE_CNT  = 5;
    localparam int DEF_REPEAT_DLY  = 50;
    localparam int DEF_REPEAT_RATE = 10;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - per-button debounce, edge pulses and autorepeat FSM
module btn_channel
    import button_ctrl_pkg::*;
#(
    parameter int STABLE_CNT  = DEF_STABLE_CNT,
    parameter int REPEAT_DLY  = DEF_REPEAT_DLY,
    parameter int REPEAT_RATE = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic sample,
    output logic held,
    output logic press,
    output logic released,
    output logic rpt
);

    localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int DW   = cnt_width(STABLE_CNT);
    localparam int RW   = cnt_width(RMAX);

    localparam logic [DW-1:0] STABLE_V = DW'(STABLE_CNT);
    localparam logic [RW-1:0] DLY_V    = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] RATE_V   = RW'(REPEAT_RATE);

    logic [DW-1:0] db_cnt;
    logic [RW-1:0] rcnt;
    rpt_state_t    state;

    logic [DW-1:0] db_next;
    logic [RW-1:0] r_next;
    logic          flip;

    assign db_next = db_cnt + DW'(1);
    assign r_next  = rcnt + RW'(1);
    assign flip    = (sample != held) && (db_next == STABLE_V);

    // A held edge on this tick overrides any repeat expiry due on the same tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            held     <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
            rpt      <= 1'b0;
            rcnt     <= '0;
            state    <= IDLE;
        end else begin
            press    <= 1'b0;
            released <= 1'b0;
            rpt      <= 1'b0;
            if (tick) begin
                if (sample != held) begin
                    if (flip) begin
                        held     <= sample;
                        db_cnt   <= '0;
                        press    <= sample;
                        released <= ~sample;
                    end else begin
                        db_cnt <= db_next;
                    end
                end else begin
                    db_cnt <= '0;
                end

                if (flip && !sample) begin
                    state <= IDLE;
                    rcnt  <= '0;
                end else if (flip && sample) begin
                    state <= DELAY;
                    rcnt  <= '0;
                end else begin
                    case (state)
                        DELAY: begin
                            if (r_next == DLY_V) begin
                                rpt   <= 1'b1;
                                rcnt  <= '0;
                                state <= REPEAT;
                            end else begin
                                rcnt <= r_next;
                            end
                        end
                        REPEAT: begin
                            if (r_next == RATE_V) begin
                                rpt  <= 1'b1;
                                rcnt <= '0;
                            end else begin
                                rcnt <= r_next;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            rcnt  <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/button_ctrl.sv
// rtl/button_ctrl.sv - button controller top: synchronizers, shared sample tick, channel array
module button_ctrl
    import button_ctrl_pkg::*;
#(
    parameter int N_BTN       = DEF_N_BTN,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int STABLE_CNT  = DEF_STABLE_CNT,
    parameter int REPEAT_DLY  = DEF_REPEAT_DLY,
    parameter int REPEAT_RATE = DEF_REPEAT_RATE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             en,
    output logic             tick,
    output logic [N_BTN-1:0] held,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] released,
    output logic [N_BTN-1:0] rpt
);

    localparam int TW = cnt_width(CLK_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [TW-1:0]    div_cnt;

    // Synchronizers keep running while disabled so re-enable sees a settled level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!en || div_cnt == TICK_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + TW'(1);
        end
    end

    assign tick = en && (div_cnt == TICK_LAST);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .STABLE_CNT (STABLE_CNT),
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_RATE(REPEAT_RATE)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .sample  (sync2[i]),
            .held    (held[i]),
            .press   (press[i]),
            .released(released[i]),
            .rpt     (rpt[i])
        );
    end

endmodule

// File: tb/tb_button_ctrl.sv
// tb/tb_button_ctrl.sv - scoreboard bench for button_ctrl
module tb_button_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] btn_in;
    logic       tick;
    logic [3:0] held;
    logic [3:0] press;
    logic [3:0] released;
    logic [3:0] rpt;

    always #5 clk = ~clk;

    button_ctrl #(
        .N_BTN      (4),
        .CLK_DIV    (4),
        .STABLE_CNT (3),
        .REPEAT_DLY (4),
        .REPEAT_RATE(2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_in  (btn_in),
        .en      (en),
        .tick    (tick),
        .held    (held),
        .press   (press),
        .released(released),
        .rpt     (rpt)
    );

    typedef struct {
        int         t;
        logic [3:0] p;
        logic [3:0] r;
        logic [3:0] rp;
        logic [3:0] h;
    } ev_t;

    ev_t  sb[$];
    int   total   = 0;
    int   bad     = 0;
    int   tick_no = 0;
    int   ph      = 0;
    logic exp_tick;
    ev_t  e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int t, input logic [3:0] p, input logic [3:0] r,
                        input logic [3:0] rp, input logic [3:0] h);
        ev_t x;
        x.t  = t;
        x.p  = p;
        x.r  = r;
        x.rp = rp;
        x.h  = h;
        sb.push_back(x);
    endtask

    task automatic wait_until(input int n);
        int g = 0;
        while (tick_no < n && g < 500) begin
            @(posedge clk);
            g++;
        end
        if (g >= 500) chk("timeout", 32'(tick_no), 32'(n));
        #2;
    endtask

    // ph tracks the divider phase expected in the cycle following each falling edge.
    initial forever begin
        @(negedge clk);
        exp_tick = rst_n && en && (ph == 3);
        chk("tick", 32'(tick), 32'(exp_tick));
        if ((press | released | rpt) != 4'b0000) begin
            if (sb.size() == 0) begin
                chk("unexpected_ev", 32'({press, released, rpt}), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ev_tick", 32'(tick_no), 32'(e.t));
                chk("ev_press", 32'(press), 32'(e.p));
                chk("ev_release", 32'(released), 32'(e.r));
                chk("ev_rpt", 32'(rpt), 32'(e.rp));
                chk("ev_held", 32'(held), 32'(e.h));
            end
        end
        if (exp_tick) tick_no++;
        ph = (!rst_n || !en) ? 0 : ((ph == 3) ? 0 : ph + 1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int n;
        int nt;
        int t0;
        int p0;

        rst_n  = 1'b0;
        en     = 1'b0;
        btn_in = 4'b0000;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_held", 32'(held), 32'd0);
        chk("rst_pulses", 32'({press, released, rpt}), 32'd0);

        rst_n = 1'b1;
        @(posedge clk);
        #2;
        en = 1'b1;
        n  = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n = i;
            if (tick) break;
        end
        chk("first_tick", 32'(n), 32'd4);
        chk("idle_outs", 32'({held, press, released, rpt}), 32'd0);
        @(posedge clk);
        #2;

        // press, delayed repeat, then release whose tick coincides with a repeat expiry
        wait_until(tick_no + 1);
        t0 = tick_no;
        btn_in[0] = 1'b1;
        p0 = t0 + 3;
        push(p0,     4'b0001, 4'b0000, 4'b0000, 4'b0001);
        push(p0 + 4, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        push(p0 + 6, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        wait_until(p0 + 5);
        btn_in[0] = 1'b0;
        push(p0 + 8, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        wait_until(p0 + 10);
        chk("a_held", 32'(held), 32'd0);

        // short glitch on ch1, simultaneous activity on ch2/ch3
        wait_until(tick_no + 1);
        t0 = tick_no;
        btn_in[1] = 1'b1;
        wait_until(t0 + 2);
        btn_in = 4'b1100;
        push(t0 + 5,  4'b1100, 4'b0000, 4'b0000, 4'b1100);
        push(t0 + 9,  4'b0000, 4'b0000, 4'b1100, 4'b1100);
        push(t0 + 11, 4'b0000, 4'b0000, 4'b1100, 4'b1100);
        wait_until(t0 + 4);
        chk("glitch_held", 32'(held[1]), 32'd0);
        wait_until(t0 + 11);
        btn_in = 4'b0000;
        push(t0 + 13, 4'b0000, 4'b0000, 4'b1100, 4'b1100);
        push(t0 + 14, 4'b0000, 4'b1100, 4'b0000, 4'b0000);
        wait_until(t0 + 16);
        chk("b_held", 32'(held), 32'd0);

        // disable during DELAY; remaining ticks resume after re-enable
        wait_until(tick_no + 1);
        t0 = tick_no;
        btn_in[0] = 1'b1;
        p0 = t0 + 3;
        push(p0, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        wait_until(p0 + 2);
        en = 1'b0;
        nt = 0;
        repeat (10) begin
            @(negedge clk);
            if (tick) nt++;
        end
        chk("en0_ticks", 32'(nt), 32'd0);
        chk("en0_held", 32'(held), 32'd1);
        @(posedge clk);
        #2;
        en = 1'b1;
        push(p0 + 4, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        push(p0 + 6, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        push(p0 + 8, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        wait_until(p0 + 7);

        // asynchronous reset mid-debounce (ch1) and mid-repeat (ch0)
        btn_in[1] = 1'b1;
        wait_until(p0 + 9);
        #1;
        rst_n  = 1'b0;
        btn_in = 4'b0000;
        #1;
        chk("rst_async", 32'({tick, held, press, released, rpt}), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        t0 = tick_no;
        wait_until(t0 + 8);
        chk("post_rst_held", 32'(held), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
